// File: rtl/fnv_1a_32_checker.sv
// FNV-1a 32 receive-side frame checker: hashes a payload, then compares it against a trailing 4-byte digest.
// Optional FNV_CHECK_ERRCNT_EN adds a saturating mismatch counter (err_count) with synchronous clear (err_clr).
module fnv_1a_32_checker #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [31:0] hash_out
`ifdef FNV_CHECK_ERRCNT_EN
    ,
    input  logic        err_clr,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        HASH   = 2'd0,
        DIGEST = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        frame_start;
    logic [1:0]  dcnt;
    logic [31:0] hash;
    logic [31:0] expected;
    logic        xfer;
    logic        last_digest;
    logic [31:0] hash_base;
    logic [31:0] digest_full;

    function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] x;
        x = h ^ {24'b0, b};
        return x * FNV_PRIME;
    endfunction

    assign in_ready    = (state != REPORT);
    assign xfer        = in_valid && in_ready;
    assign last_digest = (state == DIGEST) && xfer && (dcnt == 2'd3);
    assign hash_base   = frame_start ? OFFSET_BASIS : hash;
    // Digest as it will look once the byte currently on the bus is shifted in.
    assign digest_full = {expected[23:0], in_data};
    assign busy        = (state == DIGEST) || ((state == HASH) && !frame_start);
    assign hash_out    = hash;

    always_comb begin
        state_nxt = state;
        case (state)
            HASH:    if (xfer && in_last) state_nxt = DIGEST;
            DIGEST:  if (last_digest)     state_nxt = REPORT;
            REPORT:  state_nxt = HASH;
            default: state_nxt = HASH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HASH;
            frame_start <= 1'b1;
            dcnt        <= 2'd0;
            hash        <= OFFSET_BASIS;
            expected    <= 32'd0;
            done        <= 1'b0;
            match       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last_digest;
            match <= last_digest && (hash == digest_full);
            case (state)
                HASH: begin
                    if (xfer) begin
                        hash        <= fnv_step(hash_base, in_data);
                        frame_start <= 1'b0;
                        if (in_last) dcnt <= 2'd0;
                    end
                end
                DIGEST: begin
                    if (xfer) begin
                        expected <= digest_full;
                        dcnt     <= dcnt + 2'd1;
                    end
                end
                REPORT: frame_start <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef FNV_CHECK_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'd0;
        end else if (err_clr) begin
            err_count <= 16'd0;
        end else if (done && !match && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fnv_1a_32_checker.sv
// Scoreboard bench for fnv_1a_32_checker: expected {match, hash} queued per frame, checked on each done pulse.
module tb_fnv_1a_32_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        busy;
    logic        done;
    logic        match;
    logic [31:0] hash_out;
`ifdef FNV_CHECK_ERRCNT_EN
    logic        err_clr;
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [32:0] sb_q[$];
    logic [7:0]  pl [0:7];

    localparam logic [31:0] BASIS   = 32'h811C9DC5;
    localparam logic [31:0] H_A     = 32'hE40C292C;
    localparam logic [31:0] H_FOOBAR = 32'hBF9CF968;

    fnv_1a_32_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .busy     (busy),
        .done     (done),
        .match    (match),
        .hash_out (hash_out)
`ifdef FNV_CHECK_ERRCNT_EN
        ,
        .err_clr  (err_clr),
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: done pops the scoreboard; between frames match must stay low.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_report", {31'b0, in_ready}, {31'b0, ~done});
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("match", {31'b0, match}, {31'b0, e[32]});
                    chk("hash_out", hash_out, e[31:0]);
                end
            end else begin
                chk("match_idle", {31'b0, match}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] digest, input logic [31:0] exp_hash,
                              input bit gaps);
        sb_q.push_back({digest == exp_hash, exp_hash});
        chk("busy_before", {31'b0, busy}, 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(pl[i], i == n - 1, gaps);
            chk("busy_payload", {31'b0, busy}, 32'd1);
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(digest[i*8 +: 8], 1'b0, gaps);
            if (i != 0) chk("busy_digest", {31'b0, busy}, 32'd1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", sb_q.size(), 32'd0);
    endtask

    task automatic load_a();
        pl[0] = 8'h61;
    endtask

    task automatic load_foobar();
        pl[0] = 8'h66; pl[1] = 8'h6F; pl[2] = 8'h6F;
        pl[3] = 8'h62; pl[4] = 8'h61; pl[5] = 8'h72;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
`ifdef FNV_CHECK_ERRCNT_EN
        err_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hash", hash_out, BASIS);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_match", {31'b0, match}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
`ifdef FNV_CHECK_ERRCNT_EN
        chk("rst_errcnt", {16'b0, err_count}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_a();
        send_frame(1, H_A, H_A, 1'b0);
        wait_drain();

        load_foobar();
        send_frame(6, H_FOOBAR, H_FOOBAR, 1'b0);
        wait_drain();

        send_frame(6, 32'hBF9CF969, H_FOOBAR, 1'b0);
        wait_drain();
`ifdef FNV_CHECK_ERRCNT_EN
        chk("errcnt_inc", {16'b0, err_count}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("errcnt_clr", {16'b0, err_count}, 32'd0);
`endif

        load_a();
        for (int r = 0; r < 3; r++) begin
            send_frame(1, H_A, H_A, 1'b1);
            wait_drain();
        end

        // Abort a frame mid-payload: nothing may be reported and the hash returns to the basis.
        load_foobar();
        for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_hash", hash_out, BASIS);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_a();
        send_frame(1, H_A, H_A, 1'b0);
        wait_drain();

        // Back-to-back frames: second frame must restart from the basis.
        send_frame(1, H_A, H_A, 1'b0);
        load_foobar();
        send_frame(6, H_FOOBAR, H_FOOBAR, 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
